// File: rtl/pipTypes.sv
// ---------------------------------------------------------------------------
// pipTypes - shared pipeline types.
//   fetch_state_t : fetch-stage sequencer states (boot, run, kill)
//   fetch_entry_t : one fetch-buffer entry {pc, word}
//   INST_NOP      : word presented to decode when nothing is valid; it writes
//                   register 0, so decode never sees a hazard from it
//   next_word_addr: sequential word address, 32-bit wrap
// ---------------------------------------------------------------------------
package pipTypes;

   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_KILL = 2'd2
   } fetch_state_t;

   localparam logic [31:0] INST_NOP = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_entry_t;

   function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo - small synchronous FIFO of {pc, word} fetch entries.
//   clock, reset_n : clock, asynchronous active-low reset
//   push, wdata    : write an entry (accepted when not full, or full with pop)
//   pop            : retire the head entry (ignored when empty)
//   flush          : empty the FIFO; overrides push and pop
//   count          : number of valid entries
//   empty, full    : occupancy flags
//   head           : oldest entry, read combinationally from the entry regs
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_fifo
   import pipTypes::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         push,
   input  fetch_entry_t                 wdata,
   input  logic                         pop,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full,
   output fetch_entry_t                 head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   fetch_entry_t  entry_reg [DEPTH];

   logic do_push;
   logic do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign do_push = push && !flush && (!full || do_pop);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry storage needs no reset: nothing reads it while count is zero.
   always_ff @(posedge clock) begin
      if (do_push) entry_reg[wr_ptr_reg] <= wdata;
   end

   assign head  = entry_reg[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch - instruction fetch stage.
//   clock, reset_n        : clock, asynchronous active-low reset
//   stall                 : decode cannot take the head entry this cycle
//   redirect, redirect_pc : taken branch/jump from EX and its target
//   imem_req, imem_addr   : word read request to instruction memory
//   imem_ack, imem_rdata  : read completion, data valid in the ack cycle
//   inst_valid            : head entry is a real instruction
//   pc, inst_word         : head entry (0 / NOP when empty)
//   pc_plus_4             : pc + 4, wrapping
// Holds the fetch PC (fpc), keeps at most one memory access outstanding and
// buffers returned words in fetch_fifo. A redirect while an access is still
// pending moves to KILL, which keeps the old request stable until its ack
// and then throws the data away.
// ---------------------------------------------------------------------------
module ifetch
   import pipTypes::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] inst_word,
   output logic [31:0] pc_plus_4
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_t  state_reg;
   logic [31:0]   fpc_reg;
   logic [31:0]   kill_addr_reg;

   logic          fifo_push;
   logic          fifo_pop;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic          fifo_full;
   fetch_entry_t  fifo_wdata;
   fetch_entry_t  fifo_head;

   // Request side depends only on registered state so it stays stable for
   // the whole access, independent of stall and redirect.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = fpc_reg;
      case (state_reg)
         FETCH_RUN:  imem_req = (fifo_count < CW'(FIFO_DEPTH));
         FETCH_KILL: begin
            imem_req  = 1'b1;
            imem_addr = kill_addr_reg;
         end
         default:    imem_req = 1'b0;
      endcase
   end

   assign fifo_wdata = '{pc: fpc_reg, word: imem_rdata};
   assign fifo_push  = (state_reg == FETCH_RUN) && imem_req && imem_ack && !redirect
                       && (!fifo_full || fifo_pop);
   // Redirect flushes, so a pop in the redirect cycle is meaningless.
   assign fifo_pop   = !fifo_empty && !stall && !redirect;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= FETCH_BOOT;
         fpc_reg       <= RESET_PC;
         kill_addr_reg <= 32'h0000_0000;
      end else begin
         case (state_reg)
            FETCH_BOOT: begin
               state_reg <= FETCH_RUN;
               if (redirect) fpc_reg <= redirect_pc;
            end
            FETCH_RUN: begin
               if (redirect) begin
                  fpc_reg <= redirect_pc;
                  // Access still pending: remember its address and discard it later.
                  if (imem_req && !imem_ack) begin
                     kill_addr_reg <= imem_addr;
                     state_reg     <= FETCH_KILL;
                  end
               end else if (fifo_push) begin
                  fpc_reg <= next_word_addr(fpc_reg);
               end
            end
            FETCH_KILL: begin
               if (redirect) fpc_reg   <= redirect_pc;
               if (imem_ack) state_reg <= FETCH_RUN;
            end
            default: state_reg <= FETCH_BOOT;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (fifo_push),
      .wdata   (fifo_wdata),
      .pop     (fifo_pop),
      .flush   (redirect),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .head    (fifo_head)
   );

   assign inst_valid = !fifo_empty;
   assign pc         = fifo_empty ? 32'h0000_0000 : fifo_head.pc;
   assign inst_word  = fifo_empty ? INST_NOP      : fifo_head.word;
   assign pc_plus_4  = next_word_addr(pc);

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch - randomized bench for ifetch. A memory model answers requests
// with fixed or random wait states. The reference model is the architectural
// instruction stream: a queue of the PCs decode should receive next (restarted
// at RESET_PC or at each redirect target), plus an occupancy count of the
// fetch buffer derived from handshakes seen at the ports.
// ---------------------------------------------------------------------------
module tb_ifetch;
   import pipTypes::*;

   localparam int          DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] inst_word;
   logic [31:0] pc_plus_4;

   int checks = 0;
   int errors = 0;

   ifetch #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .pc          (pc),
      .inst_word   (inst_word),
      .pc_plus_4   (pc_plus_4)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory model ----------------
   int fixed_wait = 0;
   bit rand_wait  = 0;
   int wcnt       = 0;
   int cur_wait   = 0;

   always @(posedge clock) begin
      if (!reset_n || imem_ack === 1'b1) begin
         wcnt     = 0;
         cur_wait = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
      end
      #1;
      if (reset_n && imem_req) begin
         if (wcnt >= cur_wait) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hBAD0_0000 | wcnt;
            wcnt++;
         end
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = 32'h0000_0000;
      end
   end

   // ---------------- reference model + monitor ----------------
   logic [31:0] exp_q[$];
   int          occ = 0;
   bit          kill = 0;
   bit          booted = 0;
   bit          expect_first = 0;
   logic [31:0] target = 32'h0;
   logic [31:0] kill_addr_m = 32'h0;
   bit          prev_pend = 0;
   logic [31:0] prev_addr = 32'h0;

   task automatic restart_stream(input logic [31:0] start);
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(start + 32'(4 * i));
      target       = start;
      expect_first = 1;
   endtask

   always @(negedge clock) begin : monitor
      bit          exp_req;
      bit          pop_m;
      bit          push_m;
      logic [31:0] head;
      if (!reset_n) begin
         occ       = 0;
         kill      = 0;
         booted    = 0;
         prev_pend = 0;
         restart_stream(RST_PC);
      end else if (!booted) begin
         chk("boot_req", imem_req, 0);
         chk("boot_valid", inst_valid, 0);
         booted    = 1;
         prev_pend = 0;
         if (redirect) restart_stream(redirect_pc);
      end else begin
         exp_req = kill ? 1'b1 : (occ < DEPTH);
         chk("req", imem_req, exp_req);
         if (prev_pend) chk("req_addr_hold", imem_addr, prev_addr);
         if (kill) begin
            chk("kill_addr", imem_addr, kill_addr_m);
         end else if (expect_first && imem_req) begin
            chk("first_req_addr", imem_addr, target);
            expect_first = 0;
         end
         if (imem_req) chk("addr_align", imem_addr & 32'h3, 0);
         chk("valid", inst_valid, occ > 0);
         if (occ > 0) begin
            head = exp_q[0];
            chk("head_pc", pc, head);
            chk("head_word", inst_word, mem_word(head));
            chk("head_pc_plus_4", pc_plus_4, head + 32'd4);
         end else begin
            chk("empty_pc", pc, 32'h0);
            chk("empty_word", inst_word, INST_NOP);
            chk("empty_pc_plus_4", pc_plus_4, 32'h4);
         end
         pop_m  = (occ > 0) && !stall && !redirect;
         push_m = exp_req && imem_ack && !kill && !redirect;
         if (pop_m) begin
            $display("pop  pc=%h word=%h", exp_q[0], mem_word(exp_q[0]));
            void'(exp_q.pop_front());
            exp_q.push_back(exp_q[$] + 32'd4);
         end
         if (kill) begin
            kill = !imem_ack;
         end else if (redirect && exp_req && !imem_ack) begin
            kill        = 1;
            kill_addr_m = imem_addr;
         end
         if (redirect) begin
            $display("redir to %h", redirect_pc);
            occ = 0;
            restart_stream(redirect_pc);
         end else begin
            occ = occ + int'(push_m) - int'(pop_m);
         end
         prev_pend = imem_req && !imem_ack;
         prev_addr = imem_addr;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic do_reset(input int wait_states);
      reset_n = 1'b0;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_word", inst_word, 32'h0);
      chk("rst_pc", pc, 32'h0);
      fixed_wait = wait_states;
      rand_wait  = 0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   task automatic wait_for_addr(input logic [31:0] a);
      int n = 0;
      while (!(imem_req && imem_addr == a) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_addr: no request to %h within 100 cycles", a);
      end
   endtask

   task automatic wait_for_ack();
      int n = 0;
      while (imem_ack !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_ack: no ack within 100 cycles");
      end
   endtask

   initial begin
      logic [31:0] r;
      reset_n     = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;

      // zero-wait stream
      repeat (3) step();
      reset_n = 1'b1;
      repeat (12) step();

      // stall fills the FIFO
      stall = 1'b1;
      repeat (5) step();
      stall = 1'b0;
      repeat (8) step();

      // redirect while the fetch of 0x8 waits on a 3-wait memory
      do_reset(3);
      wait_for_addr(32'h0000_0008);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      step();
      redirect = 1'b0;
      repeat (25) step();

      // redirect, ack and stall in one cycle
      do_reset(0);
      repeat (6) step();
      stall = 1'b1;
      wait_for_ack();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      step();
      redirect = 1'b0;
      repeat (3) step();
      stall = 1'b0;
      repeat (8) step();

      // PC wrap
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      repeat (8) step();

      // random traffic
      rand_wait = 1;
      for (int i = 0; i < 800; i++) begin
         r           = $urandom;
         stall       = (($urandom % 4) == 0);
         redirect    = (($urandom % 16) == 0);
         redirect_pc = (r[3:0] == 4'h0) ? 32'hFFFF_FFF8 : (r & 32'h0000_FFFC);
         step();
      end
      stall    = 1'b0;
      redirect = 1'b0;
      rand_wait = 0;

      // asynchronous reset mid-stream
      repeat (5) step();
      do_reset(0);
      repeat (10) step();

      repeat (2) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage. Holds the fetch PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned words in a small FIFO. Presents `pc`, `inst_word` and `pc_plus_4` to the combinational decode stage directly downstream. Honours the decode `stall` and flushes on a taken branch or jump redirect from execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `FIFO_DEPTH`, default 2: fetch buffer entries. Power of two, ≥2.
- `clock` in 1: the single clock.
- `reset_n` in 1: reset, asynchronous, active-low. This is already decided.
- `stall` in 1: decode cannot accept the head entry this cycle.
- `redirect` in 1: a branch or jump was taken in EX.
- `redirect_pc` in 32: target address, valid with `redirect`.
- `imem_req` out 1: read request.
- `imem_addr` out 32: word address (bits [1:0] are always 0).
- `imem_ack` in 1: read complete. `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: the FIFO head is a real instruction.
- `pc` out 32: PC of the head entry.
- `inst_word` out 32: head instruction word.
- `pc_plus_4` out 32: `pc` + 4, truncated to 32 bits (wraps).

## Operation
- **State machine** uses `fetch_state_t`:
  - **BOOT** is the reset state. `imem_req`=0. Goes to FETCH on the first edge after reset release.
  - **FETCH**:
    - `imem_req` = (count < `FIFO_DEPTH`), with `imem_addr` = `fpc`.
    - On `imem_ack` without redirect: push {`fpc`, `imem_rdata`}, then `fpc` += 4 (32-bit wrap).
  - **KILL**: an access is in flight and its data must be discarded.
    - `imem_req`=1, with `imem_addr` = `kill_addr`.
    - On `imem_ack`: drop the data and go to FETCH.
- **Memory handshake**:
  - Once `imem_req` is asserted, `imem_req` and `imem_addr` stay stable until `imem_ack`.
  - At most one access is outstanding.
- **Pop**: occurs when `inst_valid` && !`stall`.
  - Push and pop may happen in the same cycle, including when the FIFO is full. Count is unchanged.
- **Empty FIFO outputs**: `inst_valid`=0, `inst_word`=32'h0000_0000 (NOP, writes $0, so decode creates no hazard), `pc`=0, `pc_plus_4`=4.
- **Redirect** has priority over push, pop and `stall`:
  - The FIFO is flushed: count becomes 0 next cycle.
  - `fpc` is loaded with `redirect_pc`.
  - Redirect in FETCH with `imem_req` && !`imem_ack`: `kill_addr` ← current `imem_addr`, go to KILL.
  - Redirect in FETCH with `imem_ack` in the same cycle: the returned word is dropped and the state stays FETCH.
  - Redirect in FETCH with no request: the state stays FETCH.
  - Redirect in KILL: only `fpc` is updated.
  - Redirect in KILL with `imem_ack` in the same cycle: data dropped, go to FETCH.
  - Redirect in BOOT: `fpc` ← `redirect_pc`.
- **Reset, including mid-access**:
  - Register values: state=BOOT, `fpc`=`RESET_PC`, count=0, `kill_addr`=0.
  - Outputs: `imem_req`=0, `inst_valid`=0, `inst_word`=0, `pc`=0.
  - A memory ack that arrives after reset release for a pre-reset access is outside this block's contract. Memory must also be reset.

## Timing
- **Zero-wait memory** (`imem_ack` in the request cycle N): the instruction appears at the outputs in cycle N+1. Sustained rate is 1 instruction per cycle with `stall` low.
- **W-wait memory**: the entry is visible in the cycle after the ack.
- **After reset release**:
  - First edge: BOOT to FETCH.
  - Next cycle: `imem_req`=1 with `imem_addr`=`RESET_PC`.
- **Redirect in cycle N, not in KILL**: request to `redirect_pc` in N+1. `inst_valid`=0 in N+1.
- **Redirect in cycle N, in KILL** (or entering it): request to `redirect_pc` in the cycle after the killed ack.
- **Full FIFO with `stall` held**: `imem_req` drops the cycle after the FIFO fills. No request is issued until a pop.
- **Outputs**:
  - `pc`, `inst_word`, `pc_plus_4` and `inst_valid` are combinational from the FIFO head registers only.
  - `imem_req` and `imem_addr` depend combinationally on state, count, `fpc` and `kill_addr`. They do not depend on `stall` or `redirect`.

## Structure
- **Shared package `pipTypes`**: add `fetch_state_t` {FETCH_BOOT, FETCH_RUN, FETCH_KILL} and the constant `INST_NOP` = 32'h0000_0000.
- **Sub-module `fetch_fifo`**:
  - Synchronous FIFO, 64-bit entries {pc, word}.
  - Parameterised depth.
  - Ports: `push`, `pop`, `flush`, `count`, `empty`, `full`, `head`.
  - `flush` overrides push and pop.
- **`ifetch` itself**: owns the state machine, `fpc`, `kill_addr`, the handshake and the output muxing.

## Test plan
- **Zero-wait stream**: reset, zero-wait memory, `stall`=0. Required: `pc` = 0, 4, 8, 12 on consecutive cycles from cycle 2, with `pc_plus_4` = 4, 8, 12, 16.
- **Stall fills FIFO**: hold `stall` 5 cycles during the stream. Required: `pc` is frozen, at most 2 entries are buffered, `imem_req` is low while full, and no PC is skipped or duplicated after release.
- **Redirect during wait**: memory with 3 wait states; `redirect`=1 with `redirect_pc`=32'h0000_0100 during a pending fetch of 32'h8. Required: `imem_addr` stays 32'h8 until ack, that data never appears, next request is 32'h100, next valid `pc`=32'h100.
- **Redirect same cycle as ack and stall**: assert `redirect`, `imem_ack` and `stall` in the same cycle. Required: FIFO empty next cycle, `inst_word`=0, next valid `pc`=target.
- **PC wrap**: `redirect_pc`=32'hFFFF_FFFC. Required: `pc_plus_4`=0, and the next fetch address is 32'h0000_0000.
- **Async reset mid-stream**: assert `reset_n` low between clock edges. Required: `inst_valid`=0 and `imem_req`=0 immediately, and the first request after release is to `RESET_PC`.
